// File: rtl/decode_stage_if.sv
// Fetch-to-decode inputs, writeback port and ID/EX outputs of the MIPS decode stage.
// The decode stage uses the slave modport; fetch/EX (or a bench) uses master.
interface decode_stage_if #(
  parameter int NB_DATA   = 32,
  parameter int NB_REG    = 5,
  parameter int NB_ALU_OP = 3
);
  logic [NB_DATA-1:0]   i_instruction;
  logic [NB_DATA-1:0]   i_pc_4;
  logic                 i_halt;
  logic                 i_valid;
  logic                 i_wb_we;
  logic [NB_REG-1:0]    i_wb_addr;
  logic [NB_DATA-1:0]   i_wb_data;

  logic                 o_stall;
  logic                 o_pc_src;
  logic [NB_DATA-1:0]   o_pc_salto;
  logic [NB_DATA-1:0]   o_pc_4;
  logic [NB_DATA-1:0]   o_rs_data;
  logic [NB_DATA-1:0]   o_rt_data;
  logic [NB_DATA-1:0]   o_imm;
  logic [NB_REG-1:0]    o_rs;
  logic [NB_REG-1:0]    o_rt;
  logic [NB_REG-1:0]    o_rd;
  logic [NB_REG-1:0]    o_shamt;
  logic [5:0]           o_funct;
  logic [NB_ALU_OP-1:0] o_alu_op;
  logic                 o_reg_write;
  logic                 o_mem_read;
  logic                 o_mem_write;
  logic                 o_mem_to_reg;
  logic                 o_alu_src;
  logic                 o_reg_dst;
  logic                 o_branch_eq;
  logic                 o_branch_ne;
  logic                 o_link;
  logic                 o_halt;
  logic                 o_valid_ex;

  modport master (
    output i_instruction, i_pc_4, i_halt, i_valid, i_wb_we, i_wb_addr, i_wb_data,
    input  o_stall, o_pc_src, o_pc_salto, o_pc_4, o_rs_data, o_rt_data, o_imm,
    input  o_rs, o_rt, o_rd, o_shamt, o_funct, o_alu_op,
    input  o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_reg_dst,
    input  o_branch_eq, o_branch_ne, o_link, o_halt, o_valid_ex
  );

  modport slave (
    input  i_instruction, i_pc_4, i_halt, i_valid, i_wb_we, i_wb_addr, i_wb_data,
    output o_stall, o_pc_src, o_pc_salto, o_pc_4, o_rs_data, o_rt_data, o_imm,
    output o_rs, o_rt, o_rd, o_shamt, o_funct, o_alu_op,
    output o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_reg_dst,
    output o_branch_eq, o_branch_ne, o_link, o_halt, o_valid_ex
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS ID stage: register file, control decode, load-use stall, J/JAL redirect, ID/EX register.
// Optional macro DECODE_DEBUG_PORT_EN adds a bypass-free debug read port of the register file.
module decode_stage #(
  parameter int NB_DATA   = 32,
  parameter int NB_REG    = 5,
  parameter int N_REGS    = 32,
  parameter int NB_ALU_OP = 3
) (
  input  logic          i_clock,
  input  logic          i_reset,
  decode_stage_if.slave bus
`ifdef DECODE_DEBUG_PORT_EN
  ,
  input  logic [NB_REG-1:0]  i_dbg_addr,
  output logic [NB_DATA-1:0] o_dbg_data
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [NB_ALU_OP-1:0] ALU_ADD = NB_ALU_OP'(0);
  localparam logic [NB_ALU_OP-1:0] ALU_SUB = NB_ALU_OP'(1);
  localparam logic [NB_ALU_OP-1:0] ALU_RFN = NB_ALU_OP'(2);
  localparam logic [NB_ALU_OP-1:0] ALU_AND = NB_ALU_OP'(3);
  localparam logic [NB_ALU_OP-1:0] ALU_OR  = NB_ALU_OP'(4);
  localparam logic [NB_ALU_OP-1:0] ALU_XOR = NB_ALU_OP'(5);
  localparam logic [NB_ALU_OP-1:0] ALU_LUI = NB_ALU_OP'(6);
  localparam logic [NB_ALU_OP-1:0] ALU_SLT = NB_ALU_OP'(7);

  typedef enum logic [1:0] {S_RUN, S_SQUASH, S_HALTED} state_t;

  typedef struct packed {
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_to_reg;
    logic                 alu_src;
    logic                 reg_dst;
    logic                 branch_eq;
    logic                 branch_ne;
    logic                 link;
    logic                 halt;
    logic [NB_ALU_OP-1:0] alu_op;
    logic [NB_REG-1:0]    rs;
    logic [NB_REG-1:0]    rt;
    logic [NB_REG-1:0]    rd;
    logic [NB_REG-1:0]    shamt;
    logic [5:0]           funct;
    logic [NB_DATA-1:0]   imm;
    logic [NB_DATA-1:0]   rs_data;
    logic [NB_DATA-1:0]   rt_data;
    logic [NB_DATA-1:0]   pc_4;
  } idex_t;

  function automatic logic signed [NB_DATA-1:0] sext16(input logic [15:0] v);
    return {{(NB_DATA-16){v[15]}}, v};
  endfunction

  function automatic logic [NB_DATA-1:0] zext16(input logic [15:0] v);
    return {{(NB_DATA-16){1'b0}}, v};
  endfunction

  logic [NB_DATA-1:0] regs [N_REGS];
  state_t             state;
  idex_t              idex_p1;
  logic               vld_p1;

  logic [NB_DATA-1:0] instr_p0;
  logic [5:0]         op_p0;
  logic [NB_REG-1:0]  rs_p0;
  logic [NB_REG-1:0]  rt_p0;
  logic [NB_DATA-1:0] rs_val_p0;
  logic [NB_DATA-1:0] rt_val_p0;
  idex_t              dec_p0;
  idex_t              halt_bub;
  logic               vld_p0;
  logic               is_jump_p0;
  logic               stall;

  assign instr_p0   = bus.i_instruction;
  assign op_p0      = instr_p0[31:26];
  assign rs_p0      = instr_p0[25:21];
  assign rt_p0      = instr_p0[20:16];
  assign is_jump_p0 = (op_p0 == OP_J) || (op_p0 == OP_JAL);

  // Register 0 is never written, so it reads as zero without a special case in the array.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
    end else if (bus.i_wb_we && (bus.i_wb_addr != '0)) begin
      regs[bus.i_wb_addr] <= bus.i_wb_data;
    end
  end

  always_comb begin
    rs_val_p0 = regs[rs_p0];
    rt_val_p0 = regs[rt_p0];
    if (bus.i_wb_we && (bus.i_wb_addr != '0) && (bus.i_wb_addr == rs_p0)) rs_val_p0 = bus.i_wb_data;
    if (bus.i_wb_we && (bus.i_wb_addr != '0) && (bus.i_wb_addr == rt_p0)) rt_val_p0 = bus.i_wb_data;
  end

  // Control decode; anything unrecognised collapses to an all-zero bubble.
  always_comb begin
    dec_p0 = '0;
    vld_p0 = 1'b0;
    if ((op_p0 == OP_HALT) || bus.i_halt) begin
      dec_p0.halt = 1'b1;
    end else begin
      dec_p0.rs      = rs_p0;
      dec_p0.rt      = rt_p0;
      dec_p0.rd      = instr_p0[15:11];
      dec_p0.shamt   = instr_p0[10:6];
      dec_p0.funct   = instr_p0[5:0];
      dec_p0.imm     = sext16(instr_p0[15:0]);
      dec_p0.rs_data = rs_val_p0;
      dec_p0.rt_data = rt_val_p0;
      dec_p0.pc_4    = bus.i_pc_4;
      vld_p0         = 1'b1;
      case (op_p0)
        OP_RTYPE: begin
          dec_p0.reg_dst   = 1'b1;
          dec_p0.reg_write = 1'b1;
          dec_p0.alu_op    = ALU_RFN;
        end
        OP_J: ;
        OP_JAL: begin
          dec_p0.link      = 1'b1;
          dec_p0.reg_write = 1'b1;
          dec_p0.rd        = '1;
        end
        OP_BEQ: begin
          dec_p0.branch_eq = 1'b1;
          dec_p0.alu_op    = ALU_SUB;
        end
        OP_BNE: begin
          dec_p0.branch_ne = 1'b1;
          dec_p0.alu_op    = ALU_SUB;
        end
        OP_ADDI, OP_SLTI: begin
          dec_p0.reg_write = 1'b1;
          dec_p0.alu_src   = 1'b1;
          dec_p0.alu_op    = (op_p0 == OP_ADDI) ? ALU_ADD : ALU_SLT;
        end
        OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
          dec_p0.reg_write = 1'b1;
          dec_p0.alu_src   = 1'b1;
          dec_p0.imm       = zext16(instr_p0[15:0]);
          case (op_p0)
            OP_ANDI: dec_p0.alu_op = ALU_AND;
            OP_ORI:  dec_p0.alu_op = ALU_OR;
            OP_XORI: dec_p0.alu_op = ALU_XOR;
            default: dec_p0.alu_op = ALU_LUI;
          endcase
        end
        OP_LW: begin
          dec_p0.reg_write  = 1'b1;
          dec_p0.mem_read   = 1'b1;
          dec_p0.mem_to_reg = 1'b1;
          dec_p0.alu_src    = 1'b1;
          dec_p0.alu_op     = ALU_ADD;
        end
        OP_SW: begin
          dec_p0.mem_write = 1'b1;
          dec_p0.alu_src   = 1'b1;
          dec_p0.alu_op    = ALU_ADD;
        end
        default: begin
          dec_p0 = '0;
          vld_p0 = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    halt_bub      = '0;
    halt_bub.halt = 1'b1;
  end

  // Hazard and redirect look at the raw rs/rt fields, whatever the instruction format.
  assign stall = (state != S_HALTED) && idex_p1.mem_read && (idex_p1.rt != '0) &&
                 ((idex_p1.rt == rs_p0) || (idex_p1.rt == rt_p0));

  assign bus.o_stall    = stall;
  assign bus.o_pc_src   = is_jump_p0 && (state == S_RUN) && bus.i_valid && !stall;
  assign bus.o_pc_salto = {bus.i_pc_4[31:28], instr_p0[25:0], 2'b00};

  // ---- ID/EX register boundary ----
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state   <= S_RUN;
      idex_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (bus.i_valid) begin
      case (state)
        S_HALTED: begin
          idex_p1 <= halt_bub;
          vld_p1  <= 1'b0;
        end
        S_SQUASH: begin
          idex_p1 <= '0;
          vld_p1  <= 1'b0;
          if (!stall) state <= S_RUN;
        end
        default: begin
          if (stall) begin
            idex_p1 <= '0;
            vld_p1  <= 1'b0;
          end else begin
            idex_p1 <= dec_p0;
            vld_p1  <= vld_p0;
            if (dec_p0.halt)     state <= S_HALTED;
            else if (is_jump_p0) state <= S_SQUASH;
          end
        end
      endcase
    end
  end

  assign bus.o_pc_4        = idex_p1.pc_4;
  assign bus.o_rs_data     = idex_p1.rs_data;
  assign bus.o_rt_data     = idex_p1.rt_data;
  assign bus.o_imm         = idex_p1.imm;
  assign bus.o_rs          = idex_p1.rs;
  assign bus.o_rt          = idex_p1.rt;
  assign bus.o_rd          = idex_p1.rd;
  assign bus.o_shamt       = idex_p1.shamt;
  assign bus.o_funct       = idex_p1.funct;
  assign bus.o_alu_op      = idex_p1.alu_op;
  assign bus.o_reg_write   = idex_p1.reg_write;
  assign bus.o_mem_read    = idex_p1.mem_read;
  assign bus.o_mem_write   = idex_p1.mem_write;
  assign bus.o_mem_to_reg  = idex_p1.mem_to_reg;
  assign bus.o_alu_src     = idex_p1.alu_src;
  assign bus.o_reg_dst     = idex_p1.reg_dst;
  assign bus.o_branch_eq   = idex_p1.branch_eq;
  assign bus.o_branch_ne   = idex_p1.branch_ne;
  assign bus.o_link        = idex_p1.link;
  assign bus.o_halt        = idex_p1.halt;
  assign bus.o_valid_ex    = vld_p1;

`ifdef DECODE_DEBUG_PORT_EN
  assign o_dbg_data = regs[i_dbg_addr];
`endif

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the 5-stage MIPS pipeline. Sits directly downstream of the fetch stage and consumes its o_instruction / o_pc_4 / o_halt.
- Holds the 32x32 register file, decodes control, sign/zero-extends immediates and detects load-use hazards.
- Resolves J/JAL in-stage and returns the target to fetch. Registers all results into the ID/EX pipeline register.

Parameters:
NB_DATA, 32, datapath and instruction width
NB_REG, 5, register address width
N_REGS, 32, register file depth
NB_ALU_OP, 3, ALU operation code width

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous active-low reset
i_instruction  in  NB_DATA  instruction from fetch
i_pc_4  in  NB_DATA  PC+4 from fetch
i_halt  in  1  halt flag from fetch
i_valid  in  1  pipeline advance enable; 0 freezes every register
i_wb_we  in  1  writeback write enable
i_wb_addr  in  NB_REG  writeback register address
i_wb_data  in  NB_DATA  writeback data
o_stall  out  1  load-use stall request to fetch (combinational)
o_pc_src  out  1  jump taken, to fetch i_pc_src (combinational)
o_pc_salto  out  NB_DATA  jump target, to fetch i_pc_salto (combinational)
o_pc_4  out  NB_DATA  registered PC+4
o_rs_data, o_rt_data  out  NB_DATA  registered operands
o_imm  out  NB_DATA  registered extended immediate
o_rs, o_rt, o_rd  out  NB_REG  registered register fields (o_rd = 31 for JAL)
o_shamt  out  NB_REG  registered shift amount
o_funct  out  6  registered funct field
o_alu_op  out  NB_ALU_OP  000 add, 001 sub, 010 R-funct, 011 and, 100 or, 101 xor, 110 lui, 111 slt
o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_reg_dst, o_branch_eq, o_branch_ne, o_link  out  1  registered controls
o_halt  out  1  registered halt
o_valid_ex  out  1  registered 1 = real instruction, 0 = bubble

Behaviour:
- Reset (i_reset=0, async): all registered outputs and all register-file entries = 0; FSM enters RUN. Combinational outputs follow from the zeroed state.
- Latency: 1 cycle from i_instruction to the ID/EX outputs.
- Register file: reg 0 always reads 0, and writes to it are ignored. Writes happen on the rising edge when i_wb_we=1.
- Read bypass: if i_wb_we=1 and i_wb_addr equals rs or rt (and the address is non-zero), the read returns i_wb_data in the same cycle.
- Decode table, all else treated as a NOP bubble:
  - R-type (op 0): reg_dst=1, reg_write=1, alu_op 010.
  - ADDI (alu 000), SLTI (111): sign-extended immediate, alu_src=1.
  - ANDI (011), ORI (100), XORI (101): zero-extended immediate, alu_src=1.
  - LUI (110).
  - LW: mem_read, mem_to_reg, alu 000.
  - SW: mem_write, alu 000.
  - BEQ / BNE: branch_eq / branch_ne, alu 001, sign-extended immediate (branch resolved in EX).
  - J: no register write.
  - JAL: link=1, reg_write=1, rd=31.
  - HALT: op 6'b111111.
- Jumps: for J/JAL in RUN with i_valid=1:
  - o_pc_src=1 and o_pc_salto={i_pc_4[31:28], instr[25:0], 2'b00}.
  - The next instruction accepted after that is squashed, i.e. registered as a bubble (all controls 0, o_valid_ex=0).
- Load-use hazard: o_stall=1 when registered o_mem_read=1, o_rt!=0, and o_rt equals the current rs or rt. While stalled:
  - the pipeline register loads a bubble;
  - the decode input is re-presented by fetch, which holds on stall.
- FSM states:
  - RUN: normal operation.
  - SQUASH: entered on a jump taken; the next i_valid cycle registers a bubble, then returns to RUN.
  - HALTED: entered when a HALT (instruction or i_halt) is registered. o_halt=1 is held and all later inputs become bubbles. o_pc_src=0 and o_stall=0. Only reset exits this state.
- Priority: reset > i_valid=0 (hold) > HALTED > stall > SQUASH > normal decode.
- Writeback writes still occur when i_valid=0, while stalled and while HALTED.
- A jump seen while stalled is not taken until the stall clears.

Optional Feature:
- Macro DECODE_DEBUG_PORT_EN.
- Defined: adds ports i_dbg_addr (NB_REG, in) and o_dbg_data (NB_DATA, out), a combinational read of the register file for the debug unit, without the writeback bypass.
- Undefined: these ports do not exist and there is no extra logic.

Test Plan:
- Reset mid-run with reg 5 = 0x1234 → immediately after reset all outputs are 0 and reading reg 5 returns 0.
- Write reg 3 = 0xDEADBEEF via writeback while presenting ADDI $4,$3,-1 (0x2064FFFF) → next cycle o_rs_data=0xDEADBEEF (bypass), o_imm=0xFFFFFFFF, o_alu_op=000, o_alu_src=1.
- ORI $2,$0,0x8000 → o_imm=0x00008000; write reg 0 = 7 via writeback → reg 0 still reads 0.
- LW $8,0($1), then ADD $9,$8,$2 → o_stall=1 for exactly one cycle and a bubble is registered (o_valid_ex=0); the ADD follows with o_rs=8.
- JAL 0x0000040 with i_pc_4=0x10000004 → o_pc_src=1, o_pc_salto=0x10000100, o_rd=31, o_link=1; the following instruction is registered as a bubble.
- HALT opcode → o_halt=1 held; subsequent ADDs produce o_reg_write=0 and o_valid_ex=0 until reset.
